range_framer: RTL and testbench
===============================

RANGE_FRAMER -- requirements
Module: range_framer

Interface
REQ-001 Parameter: WIDTH, default 8, sample width; equals the RangeFinder data width.
REQ-002 Parameter: LEN_W, default 8, width of the frame-length input and of the sample counter.
REQ-003 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port: rst_n, input, 1, reset; synchronous, active-low.
REQ-005 Port: start, input, 1, one-cycle request to open a frame.
REQ-006 Port: frame_len, input, LEN_W, number of samples in the frame; sampled only in the cycle start is accepted.
REQ-007 Port: abort, input, 1, terminates the current frame early.
REQ-008 Port: sample_in, input, WIDTH, raw sample data.
REQ-009 Port: sample_valid, input, 1, sample_in is valid this cycle.
REQ-010 Port: data_out, output, WIDTH, registered sample presented to the RangeFinder data input.
REQ-011 Port: go, output, 1, registered one-cycle pulse coincident with the first sample of a frame on data_out.
REQ-012 Port: finish, output, 1, registered one-cycle pulse coincident with the last sample of a frame on data_out.
REQ-013 Port: busy, output, 1, high in ARMED and RUN.
REQ-014 Port: done, output, 1, one-cycle pulse in the cycle after a normal (non-aborted) finish.
REQ-015 Port: err, output, 1, sticky error flag.

Function
REQ-016 The FSM SHALL have states IDLE, ARMED, RUN and CLOSE; IDLE is the reset state.
REQ-017 In IDLE, start=1 with frame_len>=2 SHALL latch frame_len, clear err, and enter ARMED on the next edge.
REQ-018 In IDLE, start=1 with frame_len<2 SHALL set err and remain in IDLE; no go is issued, because go and finish in the same cycle is illegal downstream.
REQ-019 start SHALL be ignored outside IDLE; it does not set err.
REQ-020 In ARMED, the first sample_valid SHALL register sample_in into data_out, pulse go the next cycle, load count=1, and enter RUN.
REQ-021 In RUN, each sample_valid SHALL register sample_in into data_out and increment count; gaps hold data_out unchanged, so a repeated sample does not alter the range.
REQ-022 When the sample making count equal to the latched length is registered, finish SHALL pulse with that sample on data_out, and the FSM SHALL enter CLOSE.
REQ-023 CLOSE SHALL last exactly one cycle, pulse done, and return to IDLE; a start in CLOSE is ignored.
REQ-024 Latency SHALL be one cycle from sample_in/sample_valid to data_out, go and finish.
REQ-025 abort in ARMED SHALL return to IDLE with no go and no finish, and SHALL set err.
REQ-026 abort in RUN SHALL pulse finish the next cycle with data_out held, set err, return to IDLE without done, and ignore any sample_valid in that cycle.
REQ-027 abort in the same cycle as the final sample SHALL take priority: the sample is dropped and the abort behaviour of REQ-026 applies.
REQ-028 abort in IDLE or CLOSE SHALL have no effect.
REQ-029 go and finish SHALL never be high in the same cycle; at most one go and one finish occur per frame.
REQ-030 count SHALL saturate at the latched length and never wrap; frame_len = 2^LEN_W-1 is supported.

Reset
REQ-031 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear data_out=0, go=0, finish=0, busy=0, done=0, err=0 and count=0, from any state.
REQ-032 A reset mid-frame SHALL produce no finish pulse; downstream is reset by the same rst_n.
REQ-033 Inputs SHALL be ignored while rst_n=0.

Verification
REQ-034 Normal frame: start, frame_len=4, samples 10,200,3,50 back-to-back -> go with 10, finish with 50, done one cycle later, RangeFinder range=197, err=0.
REQ-035 Gapped frame: frame_len=3, samples 7,_,_,9,_,1 -> data_out holds 7 then 9 during the gaps, finish with 1, range=8.
REQ-036 Illegal length: start with frame_len=1, then with frame_len=0 -> err=1, busy stays 0, no go.
REQ-037 Abort in RUN after samples 5,60 of a frame_len=10 frame -> finish pulses the next cycle with data_out=60, err=1, no done, FSM in IDLE.
REQ-038 Abort coincident with the last sample of a frame_len=2 frame (samples 4,90) -> 90 not presented, finish with data_out=4, err=1.
REQ-039 Reset mid-RUN, then a new start with frame_len=2 -> all outputs 0 after reset, and the new frame completes normally with err=0.

Source files
------------

// File: rtl/range_framer.sv
// Frames a stream of samples for the RangeFinder: opens on start, marks the first
// and last sample with go/finish, and handles aborts and illegal lengths.
module range_framer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             abort,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_CLOSE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic             len_ok;
  logic             last_hit;

  logic load_len, set_err, clr_err, capture;
  logic go_set, fin_set, done_set, cnt_load, cnt_inc;

  // A one-sample frame would need go and finish together, which downstream rejects.
  assign len_ok   = (frame_len >= LEN_W'(2));
  assign last_hit = (count == (len_q - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && len_ok) state_nxt = S_ARMED;
      S_ARMED: begin
        if (abort)             state_nxt = S_IDLE;
        else if (sample_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (abort)                         state_nxt = S_IDLE;
        else if (sample_valid && last_hit) state_nxt = S_CLOSE;
      end
      S_CLOSE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    load_len  = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    capture   = 1'b0;
    go_set    = 1'b0;
    fin_set   = 1'b0;
    done_set  = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    state_dbg = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            load_len = 1'b1;
            clr_err  = 1'b1;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      S_ARMED: begin
        busy = 1'b1;
        if (abort) begin
          set_err = 1'b1;
        end else if (sample_valid) begin
          capture  = 1'b1;
          go_set   = 1'b1;
          cnt_load = 1'b1;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // Abort wins over a coincident sample, even the final one.
        if (abort) begin
          set_err = 1'b1;
          fin_set = 1'b1;
        end else if (sample_valid) begin
          capture = 1'b1;
          cnt_inc = 1'b1;
          fin_set = last_hit;
        end
      end
      S_CLOSE: done_set = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= '0;
      go       <= 1'b0;
      finish   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      len_q    <= '0;
      count    <= '0;
    end else begin
      go     <= go_set;
      finish <= fin_set;
      done   <= done_set;
      if (load_len) len_q <= frame_len;
      if (clr_err)      err <= 1'b0;
      else if (set_err) err <= 1'b1;
      if (capture) data_out <= sample_in;
      if (cnt_load)                       count <= LEN_W'(1);
      else if (cnt_inc && count != len_q) count <= count + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_range_framer.sv
// Bench for range_framer: a cycle table for the directed scenarios, reset and
// random frames scored against a frame-level model with a RangeFinder monitor.
module tb_range_framer;
  localparam int W  = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] frame_len;
  logic          abort;
  logic [W-1:0]  sample_in;
  logic          sample_valid;
  logic [W-1:0]  data_out;
  logic          go, finish, busy, done, err;
  logic [1:0]    state_dbg;

  range_framer #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len), .abort(abort),
    .sample_in(sample_in), .sample_valid(sample_valid), .data_out(data_out),
    .go(go), .finish(finish), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // RangeFinder stand-in: tracks min/max of data_out from go through finish.
  int           go_cnt, fin_cnt, done_cnt, both_cnt;
  int           go_data, fin_data;
  int           mon_mn, mon_mx;
  bit           tracking = 0;
  logic [W-1:0] obs_q[$];
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      tracking = 0;
    end else begin
      if (go && finish) both_cnt++;
      if (go) begin
        go_cnt++;
        go_data  = int'(data_out);
        mon_mn   = int'(data_out);
        mon_mx   = int'(data_out);
        tracking = 1;
      end else if (tracking) begin
        if (int'(data_out) < mon_mn) mon_mn = int'(data_out);
        if (int'(data_out) > mon_mx) mon_mx = int'(data_out);
      end
      if (finish) begin
        fin_cnt++;
        fin_data = int'(data_out);
        if (tracking) obs_q.push_back(W'(mon_mx - mon_mn));
        tracking = 0;
      end
      if (done) done_cnt++;
    end
  end

  typedef struct {
    logic          start;
    logic [LW-1:0] flen;
    logic          abort;
    logic          sv;
    logic [W-1:0]  din;
    logic [W-1:0]  e_data;
    logic          e_go, e_fin, e_busy, e_done, e_err;
  } vec_t;

  function automatic vec_t v(input logic st, input int fl, input logic ab, input logic sv,
                             input int din, input int ed, input logic eg, input logic ef,
                             input logic eb, input logic edn, input logic ee);
    vec_t r;
    r.start = st; r.flen = LW'(fl); r.abort = ab; r.sv = sv; r.din = W'(din);
    r.e_data = W'(ed); r.e_go = eg; r.e_fin = ef; r.e_busy = eb; r.e_done = edn; r.e_err = ee;
    return r;
  endfunction

  task automatic idle_inputs();
    start = 0; frame_len = '0; abort = 0; sample_valid = 0; sample_in = '0;
  endtask

  task automatic clear_mon();
    go_cnt = 0; fin_cnt = 0; done_cnt = 0; both_cnt = 0;
    obs_q.delete();
  endtask

  // Drives one frame; the expectation follows from which samples were accepted.
  task automatic run_frame(input string tag, input int len, input int abort_at, input int gap_pct);
    logic [W-1:0] s[$];
    int n, mn, mx, g;
    clear_mon();
    for (int i = 0; i < len; i++) s.push_back(W'($urandom_range(0, 255)));
    n = (abort_at < 0) ? len : abort_at;
    start = 1; frame_len = LW'(len);
    @(posedge clk); #1;
    start = 0; frame_len = '0;
    for (int i = 0; i < len; i++) begin
      g = 0;
      while (g < 3 && $urandom_range(0, 99) < gap_pct) begin
        sample_valid = 0; sample_in = W'($urandom);
        start = 1'($urandom_range(0, 1)); frame_len = LW'($urandom_range(0, 3));
        @(posedge clk); #1;
        g++;
      end
      start = 0; frame_len = '0;
      sample_valid = 1; sample_in = s[i]; abort = (i == abort_at);
      @(posedge clk); #1;
      sample_valid = 0; abort = 0;
      if (i == abort_at) break;
    end
    if (abort_at < 0) begin
      // This cycle is the closing one: start and abort must both be ignored.
      start = 1; frame_len = '0; abort = 1;
      @(posedge clk); #1;
      start = 0; abort = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    mn = 255; mx = 0;
    for (int i = 0; i < n; i++) begin
      if (int'(s[i]) < mn) mn = int'(s[i]);
      if (int'(s[i]) > mx) mx = int'(s[i]);
    end
    check({tag, ".go_cnt"},   go_cnt,   (n > 0) ? 1 : 0);
    check({tag, ".fin_cnt"},  fin_cnt,  (n > 0) ? 1 : 0);
    check({tag, ".done_cnt"}, done_cnt, (abort_at < 0) ? 1 : 0);
    check({tag, ".both"},     both_cnt, 0);
    check({tag, ".err"},      err,      (abort_at >= 0) ? 1 : 0);
    check({tag, ".busy"},     busy,     0);
    if (n > 0) begin
      check({tag, ".go_data"},  go_data,  int'(s[0]));
      check({tag, ".fin_data"}, fin_data, int'(s[n-1]));
      check({tag, ".ranges"},   obs_q.size(), 1);
      if (obs_q.size() == 1) check({tag, ".range"}, obs_q[0], mx - mn);
    end
  endtask

  task automatic illegal_start(input string tag, input int len);
    clear_mon();
    start = 1; frame_len = LW'(len);
    @(posedge clk); #1;
    start = 0; frame_len = '0;
    @(posedge clk); #1;
    check({tag, ".err"},  err,    1);
    check({tag, ".busy"}, busy,   0);
    check({tag, ".go"},   go_cnt, 0);
  endtask

  vec_t vt[$];

  initial begin
    rst_n = 0;
    // Inputs active during reset must leave no trace.
    start = 1; frame_len = LW'(4); abort = 0; sample_valid = 1; sample_in = W'(55);
    repeat (3) @(posedge clk);
    #1;
    check("reset.outputs", {data_out, go, finish, busy, done, err}, 0);
    check("reset.state",   state_dbg, 0);
    rst_n = 1; idle_inputs();
    @(posedge clk); #1;
    check("post_reset.outputs", {data_out, go, finish, busy, done, err}, 0);

    // Normal frame 10,200,3,50; CLOSE ignores start/abort/sample.
    vt.push_back(v(1, 4, 0, 0, 0,    0, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 1, 10,  10, 1, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 1, 200, 200, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 1, 3,    3, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 1, 50,  50, 0, 1, 0, 0, 0));
    vt.push_back(v(1, 0, 1, 1, 99,  50, 0, 0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0,   50, 0, 0, 0, 0, 0));
    // Gapped frame 7,_,_,9,_,1 with a start in RUN.
    vt.push_back(v(1, 3, 0, 0, 0,   50, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 1, 7,    7, 1, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 33,   7, 0, 0, 1, 0, 0));
    vt.push_back(v(1, 2, 0, 0, 0,    7, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 1, 9,    9, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0,    9, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 1, 1,    1, 0, 1, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0,    1, 0, 0, 0, 1, 0));
    // Illegal lengths, then abort in IDLE.
    vt.push_back(v(1, 1, 0, 0, 0,    1, 0, 0, 0, 0, 1));
    vt.push_back(v(1, 0, 0, 1, 5,    1, 0, 0, 0, 0, 1));
    vt.push_back(v(0, 0, 1, 0, 0,    1, 0, 0, 0, 0, 1));
    // Abort in RUN after 5,60 of a 10-sample frame.
    vt.push_back(v(1, 10, 0, 0, 0,   1, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 1, 5,    5, 1, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 1, 60,  60, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 1, 1, 77,  60, 0, 1, 0, 0, 1));
    vt.push_back(v(0, 0, 0, 0, 0,   60, 0, 0, 0, 0, 1));
    vt.push_back(v(0, 0, 0, 0, 0,   60, 0, 0, 0, 0, 1));
    // Abort coincident with the final sample of a 2-sample frame.
    vt.push_back(v(1, 2, 0, 0, 0,   60, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 1, 4,    4, 1, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 1, 1, 90,   4, 0, 1, 0, 0, 1));
    vt.push_back(v(0, 0, 0, 0, 0,    4, 0, 0, 0, 0, 1));
    // Abort in ARMED: no go, no finish.
    vt.push_back(v(1, 3, 0, 0, 0,    4, 0, 0, 1, 0, 0));
    vt.push_back(v(0, 0, 1, 1, 8,    4, 0, 0, 0, 0, 1));
    vt.push_back(v(0, 0, 0, 0, 0,    4, 0, 0, 0, 0, 1));

    exp_q = '{W'(197), W'(8), W'(55), W'(0)};
    clear_mon();
    for (int i = 0; i < vt.size(); i++) begin
      start = vt[i].start; frame_len = vt[i].flen; abort = vt[i].abort;
      sample_valid = vt[i].sv; sample_in = vt[i].din;
      @(posedge clk); #1;
      check($sformatf("vec[%0d]", i), {data_out, go, finish, busy, done, err},
            {vt[i].e_data, vt[i].e_go, vt[i].e_fin, vt[i].e_busy, vt[i].e_done, vt[i].e_err});
    end
    idle_inputs();
    @(posedge clk); #1;
    check("table.range_cnt", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check("table.range", obs_q.pop_front(), exp_q.pop_front());
    check("table.both", both_cnt, 0);

    // Reset mid-RUN: no finish, everything cleared, next frame is clean.
    clear_mon();
    start = 1; frame_len = LW'(5);
    @(posedge clk); #1;
    start = 0; sample_valid = 1; sample_in = W'(1);
    @(posedge clk); #1;
    sample_in = W'(2);
    @(posedge clk); #1;
    rst_n = 0; start = 1; frame_len = LW'(3); sample_in = W'(200); abort = 1;
    @(posedge clk); #1;
    check("midrst.outputs", {data_out, go, finish, busy, done, err}, 0);
    check("midrst.state",   state_dbg, 0);
    rst_n = 1; idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("midrst.no_finish", fin_cnt, 0);
    check("midrst.idle",      {busy, err}, 0);
    run_frame("after_rst", 2, -1, 0);

    // Saturation: longest frame back-to-back, then aborted at its final sample.
    run_frame("max_len", 255, -1, 0);
    run_frame("max_abort", 255, 254, 0);

    for (int f = 0; f < 40; f++) begin
      int len, ab;
      len = $urandom_range(2, 6);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      if ($urandom_range(0, 4) == 0) illegal_start($sformatf("ill%0d", f), $urandom_range(0, 1));
      run_frame($sformatf("rnd%0d", f), len, ab, 30);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
